// File: rtl/vend_pkg.sv
// ============================================================================
// Module : vend_pkg
// Brief  : Shared state encoding, coin values and limits for change_dispenser.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vend_pkg;

    localparam int unsigned TIMER_W = 4;

    localparam logic [2:0] COIN2_VAL  = 3'd2;
    localparam logic [2:0] COIN1_VAL  = 3'd1;
    localparam logic [2:0] MAX_RETURN = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VEND  = 3'd1,
        ST_COIN2 = 3'd2,
        ST_COIN1 = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage : vend_pkg

`default_nettype wire

// File: rtl/pulse_timer.sv
// ============================================================================
// Module : pulse_timer
// Brief  : Loadable down-counter; done is high while the count is zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_timer
    import vend_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               count,
    output logic               done
);

    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (count && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = (r_cnt == '0);

endmodule : pulse_timer

`default_nettype wire

// File: rtl/change_dispenser.sv
// ============================================================================
// Module : change_dispenser
// Brief  : Vends a drink then pays change greedily in 2c/1c hopper pulses.
//          Optional audit counters enabled by defining COIN_AUDIT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic [2:0] r,
    output logic       vend,
    output logic       coin2,
    output logic       coin1,
    output logic       busy,
    output logic       overrun,
    output logic       err
`ifdef COIN_AUDIT_EN
    ,
    output logic [7:0] vend_count,
    output logic [7:0] cents_count
`endif
);

    // The timer holds (length - 1) so a state lasts until the count hits zero.
    localparam logic [TIMER_W-1:0] C_PULSE_LOAD = TIMER_W'(PULSE_LEN - 1);
    localparam logic [TIMER_W-1:0] C_GAP_LOAD   = TIMER_W'(GAP_LEN - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [2:0]         r_remaining;
    logic [2:0]         w_next_remaining;
    logic               w_t_load;
    logic [TIMER_W-1:0] w_t_val;
    logic               w_t_count;
    logic               w_t_done;
    logic               w_err_next;
    logic               w_ovr_next;

    pulse_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_t_load),
        .load_val (w_t_val),
        .count    (w_t_count),
        .done     (w_t_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= 3'd0;
            vend        <= 1'b0;
            coin2       <= 1'b0;
            coin1       <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            err         <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
            vend        <= (w_next_state == ST_VEND);
            coin2       <= (w_next_state == ST_COIN2);
            coin1       <= (w_next_state == ST_COIN1);
            busy        <= (w_next_state != ST_IDLE);
            overrun     <= w_ovr_next;
            err         <= w_err_next;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_t_load         = 1'b0;
        w_t_val          = '0;
        w_t_count        = 1'b0;
        w_err_next       = 1'b0;
        w_ovr_next       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (d) begin
                    if (r > MAX_RETURN) begin
                        w_err_next = 1'b1;
                    end else begin
                        w_next_state     = ST_VEND;
                        w_next_remaining = r;
                        w_t_load         = 1'b1;
                        w_t_val          = C_PULSE_LOAD;
                    end
                end
            end
            ST_VEND: begin
                if (w_t_done) begin
                    w_next_state = ST_GAP;
                    w_t_load     = 1'b1;
                    w_t_val      = C_GAP_LOAD;
                end else begin
                    w_t_count = 1'b1;
                end
            end
            ST_COIN2: begin
                if (w_t_done) begin
                    if (r_remaining >= COIN2_VAL) begin
                        w_next_remaining = r_remaining - COIN2_VAL;
                    end
                    w_next_state = ST_GAP;
                    w_t_load     = 1'b1;
                    w_t_val      = C_GAP_LOAD;
                end else begin
                    w_t_count = 1'b1;
                end
            end
            ST_COIN1: begin
                if (w_t_done) begin
                    if (r_remaining >= COIN1_VAL) begin
                        w_next_remaining = r_remaining - COIN1_VAL;
                    end
                    w_next_state = ST_GAP;
                    w_t_load     = 1'b1;
                    w_t_val      = C_GAP_LOAD;
                end else begin
                    w_t_count = 1'b1;
                end
            end
            ST_GAP: begin
                if (w_t_done) begin
                    if (r_remaining >= COIN2_VAL) begin
                        w_next_state = ST_COIN2;
                        w_t_load     = 1'b1;
                        w_t_val      = C_PULSE_LOAD;
                    end else if (r_remaining == COIN1_VAL) begin
                        w_next_state = ST_COIN1;
                        w_t_load     = 1'b1;
                        w_t_val      = C_PULSE_LOAD;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_t_count = 1'b1;
                end
            end
            default: begin
                w_next_state     = ST_IDLE;
                w_next_remaining = 3'd0;
            end
        endcase

        // Requests arriving mid-transaction are dropped, not queued.
        if ((r_state != ST_IDLE) && d) begin
            w_ovr_next = 1'b1;
        end
    end

`ifdef COIN_AUDIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            vend_count  <= 8'd0;
            cents_count <= 8'd0;
        end else begin
            if ((r_state != ST_VEND) && (w_next_state == ST_VEND)) begin
                vend_count <= vend_count + 8'd1;
            end
            if ((r_state == ST_COIN2) && w_t_done) begin
                cents_count <= cents_count + 8'(COIN2_VAL);
            end else if ((r_state == ST_COIN1) && w_t_done) begin
                cents_count <= cents_count + 8'(COIN1_VAL);
            end
        end
    end
`endif

endmodule : change_dispenser

`default_nettype wire

// File: tb/tb_change_dispenser.sv
// ============================================================================
// Module : tb_change_dispenser
// Brief  : Directed self-checking bench for change_dispenser (PULSE_LEN=2, GAP_LEN=1).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       d;
    logic [2:0] r;
    logic       vend, coin2, coin1, busy, overrun, err;
`ifdef COIN_AUDIT_EN
    logic [7:0] vend_count, cents_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    change_dispenser #(.PULSE_LEN(2), .GAP_LEN(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .d       (d),
        .r       (r),
        .vend    (vend),
        .coin2   (coin2),
        .coin1   (coin1),
        .busy    (busy),
        .overrun (overrun),
        .err     (err)
`ifdef COIN_AUDIT_EN
        ,
        .vend_count  (vend_count),
        .cents_count (cents_count)
`endif
    );

    // Observation order: {vend, coin2, coin1, busy, overrun, err}
    task automatic test_reset;
        logic [5:0] obs;
        reset = 1'b1; d = 1'b1; r = 3'd2;
        repeat (2) @(posedge clk);
        #1;
        obs = {vend, coin2, coin1, busy, overrun, err};
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL reset_state got %b want %b", obs, 6'b000000);
        end
        reset = 1'b0; d = 1'b0; r = 3'd7;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            obs = {vend, coin2, coin1, busy, overrun, err};
            checks++;
            if (obs !== 6'b000000) begin
                errors++;
                $display("FAIL idle_d0_r7 cycle %0d got %b want %b", c, obs, 6'b000000);
            end
        end
    endtask

    task automatic test_r0;
        logic [5:0] obs, exp;
        d = 1'b1; r = 3'd0;
        @(posedge clk); #1;
        d = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            exp = {(c >= 1 && c <= 2), 1'b0, 1'b0, (c >= 1 && c <= 3), 1'b0, 1'b0};
            obs = {vend, coin2, coin1, busy, overrun, err};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL r0 cycle %0d got %b want %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r3;
        logic [5:0] obs, exp;
        d = 1'b1; r = 3'd3;
        @(posedge clk); #1;
        d = 1'b0; r = 3'd0;
        for (int c = 1; c <= 12; c++) begin
            exp = {(c >= 1 && c <= 2), (c >= 4 && c <= 5), (c >= 7 && c <= 8),
                   (c >= 1 && c <= 9), 1'b0, 1'b0};
            obs = {vend, coin2, coin1, busy, overrun, err};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL r3 cycle %0d got %b want %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r4;
        logic [5:0] obs, exp;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        d = 1'b1; r = 3'd4;
        @(posedge clk); #1;
        d = 1'b0; r = 3'd0;
        for (int c = 1; c <= 12; c++) begin
            exp = {(c >= 1 && c <= 2), ((c >= 4 && c <= 5) || (c >= 7 && c <= 8)), 1'b0,
                   (c >= 1 && c <= 9), 1'b0, 1'b0};
            obs = {vend, coin2, coin1, busy, overrun, err};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL r4 cycle %0d got %b want %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
`ifdef COIN_AUDIT_EN
        checks++;
        if (cents_count !== 8'd4) begin
            errors++;
            $display("FAIL audit_cents got %0d want %0d", cents_count, 4);
        end
        checks++;
        if (vend_count !== 8'd1) begin
            errors++;
            $display("FAIL audit_vends got %0d want %0d", vend_count, 1);
        end
`endif
    endtask

    task automatic test_err;
        logic [5:0] obs, exp;
        d = 1'b1; r = 3'd6;
        @(posedge clk); #1;
        d = 1'b0; r = 3'd0;
        for (int c = 1; c <= 4; c++) begin
            exp = {5'b00000, (c == 1)};
            obs = {vend, coin2, coin1, busy, overrun, err};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL err_r6 cycle %0d got %b want %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overrun;
        logic [5:0] obs, exp;
        d = 1'b1; r = 3'd2;
        @(posedge clk); #1;
        d = 1'b0; r = 3'd0;
        for (int c = 1; c <= 9; c++) begin
            if (c == 2) begin d = 1'b1; r = 3'd1; end
            if (c == 3) begin d = 1'b0; r = 3'd0; end
            exp = {(c >= 1 && c <= 2), (c >= 4 && c <= 5), 1'b0,
                   (c >= 1 && c <= 6), (c == 3), 1'b0};
            obs = {vend, coin2, coin1, busy, overrun, err};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL overrun cycle %0d got %b want %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_abort;
        logic [5:0] obs, exp;
        d = 1'b1; r = 3'd3;
        @(posedge clk); #1;
        d = 1'b0; r = 3'd0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 4) reset = 1'b1;
            if (c == 5) reset = 1'b0;
            if (c == 6) begin d = 1'b1; r = 3'd1; end
            if (c == 7) begin d = 1'b0; r = 3'd0; end
            if (c <= 4) begin
                exp = {(c <= 2), (c == 4), 1'b0, 1'b1, 1'b0, 1'b0};
            end else begin
                exp = {(c >= 7 && c <= 8), 1'b0, (c >= 10 && c <= 11),
                       (c >= 7 && c <= 12), 1'b0, 1'b0};
            end
            obs = {vend, coin2, coin1, busy, overrun, err};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_abort cycle %0d got %b want %b", c, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b0; d = 1'b0; r = 3'd0;
        @(negedge clk);
        test_reset();
        test_r0();
        test_r3();
        test_r4();
        test_err();
        test_overrun();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_change_dispenser

`default_nettype wire

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 2, meaning the actuator pulse width in clk cycles (legal range 1-15).
REQ-002 SHALL have parameter GAP_LEN, default 1, meaning the idle gap after every pulse in clk cycles (legal range 1-15).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port d  input  1  dispense request from the coin-acceptor FSM.
REQ-007 SHALL have port r  input  3  change amount in cents, valid only while d=1.
REQ-008 SHALL have port vend  output  1  drink actuator pulse.
REQ-009 SHALL have port coin2  output  1  2-cent hopper pulse.
REQ-010 SHALL have port coin1  output  1  1-cent hopper pulse.
REQ-011 SHALL have port busy  output  1  high while any request is in progress.
REQ-012 SHALL have port overrun  output  1  one-cycle flag for a request rejected while busy.
REQ-013 SHALL have port err  output  1  one-cycle flag for an illegal change amount.

Function
REQ-014 SHALL sample d and r on every posedge clk while in IDLE; d=0 is no request, regardless of r.
REQ-015 SHALL accept a request (d=1, r<=4) in IDLE, load a remaining-change register with r, and enter VEND on the next cycle.
REQ-016 SHALL treat d=1 with r>=5 in IDLE as illegal: err=1 for exactly the next cycle, no pulses, stay IDLE.
REQ-017 SHALL implement states IDLE, VEND, COIN2, COIN1, GAP, all with registered outputs (Moore).
REQ-018 SHALL hold vend=1 for exactly PULSE_LEN cycles in VEND, then go to GAP.
REQ-019 SHALL hold GAP for exactly GAP_LEN cycles with all pulse outputs low, then go to COIN2 if remaining>=2, else COIN1 if remaining==1, else IDLE.
REQ-020 SHALL hold coin2=1 for PULSE_LEN cycles in COIN2 and subtract 2 from remaining on exit; SHALL hold coin1=1 for PULSE_LEN cycles in COIN1 and subtract 1 from remaining on exit; both then go to GAP.
REQ-021 SHALL pay change greedily: r=4 gives two coin2; r=3 gives coin2 then coin1; r=2 gives one coin2; r=1 gives one coin1.
REQ-022 SHALL keep at most one of vend, coin2, coin1 high in any cycle.
REQ-023 SHALL drive busy=1 in every non-IDLE state and busy=0 in IDLE.
REQ-024 SHALL ignore d=1 while busy, drop the request (no queuing), and pulse overrun=1 for exactly the next cycle.
REQ-025 SHALL use a 3-bit remaining register that never underflows; remaining==0 on return to IDLE.

Reset
REQ-026 SHALL, on reset=1 at a clk edge, force IDLE, remaining=0, timer=0, and vend=coin2=coin1=busy=overrun=err=0 on the following cycle.
REQ-027 SHALL abort a request mid-pulse on reset with no completion of the remaining pulses; reset SHALL take priority over d.

Configuration
REQ-028 SHALL, with COIN_AUDIT_EN defined, add output ports vend_count[7:0] (incremented on each VEND entry) and cents_count[7:0] (incremented by 2 on COIN2 exit and by 1 on COIN1 exit), both wrapping modulo 256 and cleared by reset.
REQ-029 SHALL, without COIN_AUDIT_EN, omit both ports and both counters; all other behaviour identical.

Structure
REQ-030 SHALL put the state encoding, the coin values (2, 1), and MAX_RETURN=4 in a shared package vend_pkg.
REQ-031 SHALL implement the PULSE_LEN/GAP_LEN countdown as sub-module pulse_timer (load, count, done), instantiated once.

Verification (PULSE_LEN=2, GAP_LEN=1; request sampled at edge 0, cycles numbered after it)
REQ-032 SHALL check d=1,r=0: vend=1 in cycles 1-2, gap in cycle 3, busy=0 from cycle 4, no coin pulses.
REQ-033 SHALL check d=1,r=3: vend in 1-2, coin2 in 4-5, coin1 in 7-8, busy=0 from cycle 10.
REQ-034 SHALL check d=1,r=4: vend in 1-2, coin2 in 4-5, coin2 in 7-8, no coin1; with COIN_AUDIT_EN, cents_count=4 and vend_count=1 afterwards.
REQ-035 SHALL check d=1,r=6 in IDLE: err=1 in cycle 1 only, busy stays 0, no pulses.
REQ-036 SHALL check a second d=1,r=1 applied in cycle 2 of an r=2 request: overrun=1 in cycle 3, and exactly one coin2 and no coin1 are issued.
REQ-037 SHALL check reset=1 in cycle 4 of an r=3 request: all outputs 0 from cycle 5, and a new d=1,r=1 at cycle 6 gives vend in 7-8 and coin1 in 10-11.
